// File: rtl/ps2_scan_rx_if.sv
// Key-event handshake between the PS/2 receiver and its consumer.
// PS2_ASCII_EN adds the translated evt_ascii field.
interface ps2_scan_rx_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_brk;
  logic       evt_ext;
`ifdef PS2_ASCII_EN
  logic [7:0] evt_ascii;

  modport master (output evt_valid, evt_code, evt_brk, evt_ext, evt_ascii, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_brk, evt_ext, evt_ascii, output evt_ready);
`else
  modport master (output evt_valid, evt_code, evt_brk, evt_ext, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_brk, evt_ext, output evt_ready);
`endif
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin sync/filter, 11-bit deframer, E0/F0 folding, show-ahead event FIFO.
// Optional macro PS2_ASCII_EN adds a registered scan-code to ASCII translation (evt_ascii).
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_ps2_clk_async,
  input  logic                 i_ps2_data_async,
  ps2_scan_rx_if.master        evt,
  output logic                 o_frame_err,
  output logic [7:0]           o_err_cnt,
  output logic                 o_overflow,
  input  logic                 i_ovf_clr
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef PS2_ASCII_EN
  localparam int EW = 18;
`else
  localparam int EW = 10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_clk_filt, r_clk_filt_d;
  logic [FW-1:0] r_flt_cnt;
  logic          w_strobe;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout, w_err, w_ok;
  logic          r_ext, r_brk;
  logic          r_push;
  logic [9:0]    r_push_data;
  logic [7:0]    r_err_cnt;
  logic          r_overflow;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [EW-1:0] w_wdata, w_head;
  logic          w_valid, w_full, w_pop, w_wr, w_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= i_ps2_clk_async;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= i_ps2_data_async;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Filtered clock only follows the pin after FILTER_LEN consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_flt_cnt    <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync != r_clk_filt) begin
        if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
          r_clk_filt <= r_clk_sync;
          r_flt_cnt  <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + FW'(1);
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign w_strobe  = r_clk_filt_d & ~r_clk_filt;
  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_ok        = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE:   if (!r_dat_sync) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (r_dat_sync && (^{r_shift, r_par})) w_ok  = 1'b1;
          else                                   w_err = 1'b1;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE || w_strobe || w_timeout) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + TW'(1);
      if (w_strobe) begin
        case (r_state)
          S_IDLE:   r_bit_idx <= '0;
          S_DATA: begin
            r_shift   <= {r_dat_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
          S_PARITY: r_par <= r_dat_sync;
          default:  ;
        endcase
      end
    end
  end

`ifdef PS2_ASCII_EN
  logic [7:0] r_push_ascii;

  function automatic logic [7:0] f_ascii(input logic [7:0] c, input logic brk);
    logic [7:0] a;
    case (c)
      8'h16, 8'h69: a = "1";  8'h1E, 8'h72: a = "2";  8'h26, 8'h7A: a = "3";
      8'h25, 8'h6B: a = "4";  8'h2E, 8'h73: a = "5";  8'h36, 8'h74: a = "6";
      8'h3D, 8'h6C: a = "7";  8'h3E, 8'h75: a = "8";  8'h46, 8'h7D: a = "9";
      8'h45, 8'h70: a = "0";
      8'h1C: a = "A";  8'h32: a = "B";  8'h21: a = "C";  8'h23: a = "D";
      8'h24: a = "E";  8'h2B: a = "F";  8'h34: a = "G";  8'h33: a = "H";
      8'h43: a = "I";  8'h3B: a = "J";  8'h42: a = "K";  8'h4B: a = "L";
      8'h3A: a = "M";  8'h31: a = "N";  8'h44: a = "O";  8'h4D: a = "P";
      8'h15: a = "Q";  8'h2D: a = "R";  8'h1B: a = "S";  8'h2C: a = "T";
      8'h3C: a = "U";  8'h2A: a = "V";  8'h1D: a = "W";  8'h22: a = "X";
      8'h35: a = "Y";  8'h1A: a = "Z";
      default: a = 8'h3F;
    endcase
    return brk ? 8'h3F : a;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        r_push_ascii <= '0;
    else if (w_ok && r_shift != 8'hE0 && r_shift != 8'hF0) r_push_ascii <= f_ascii(r_shift, r_brk);
  end

  assign w_wdata       = {r_push_ascii, r_push_data};
  assign evt.evt_ascii = w_valid ? w_head[17:10] : 8'h00;
`else
  assign w_wdata = r_push_data;
`endif

  // Prefix bytes only arm flags; the next ordinary byte carries and clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (w_ok) begin
        if (r_shift == 8'hE0)      r_ext <= 1'b1;
        else if (r_shift == 8'hF0) r_brk <= 1'b1;
        else begin
          r_push      <= 1'b1;
          r_push_data <= {r_ext, r_brk, r_shift};
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
        end
      end
    end
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = w_valid & evt.evt_ready;
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign evt.evt_valid = w_valid;
  assign evt.evt_code  = w_valid ? w_head[7:0] : 8'h00;
  assign evt.evt_brk   = w_valid & w_head[8];
  assign evt.evt_ext   = w_valid & w_head[9];
  assign o_frame_err   = w_err;
  assign o_err_cnt     = r_err_cnt;
  assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: bit-banged PS/2 frames with hand-computed expected events.
module tb_ps2_scan_rx;
  localparam int FL = 4, TO = 1500, DEPTH = 8, H = 20;

  logic       clk = 1'b0, reset_n = 1'b0, pc = 1'b1, pd = 1'b1, ovf_clr = 1'b0;
  logic       frame_err, overflow;
  logic [7:0] err_cnt;
  int         n_chk = 0, n_pass = 0, n_fail = 0, n_ferr = 0, f0;
  logic [9:0] evq[$];

  always #5 clk = ~clk;

  ps2_scan_rx_if evt_if();

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_ps2_clk_async(pc), .i_ps2_data_async(pd),
    .evt(evt_if), .o_frame_err(frame_err), .o_err_cnt(err_cnt),
    .o_overflow(overflow), .i_ovf_clr(ovf_clr));

  always @(negedge clk) begin
    if (evt_if.evt_valid && evt_if.evt_ready)
      evq.push_back({evt_if.evt_ext, evt_if.evt_brk, evt_if.evt_code});
    if (frame_err) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] get(input int i);
    return (evq.size() > i) ? evq[i] : 10'h3FF;
  endfunction

  task automatic bit_fall(input logic b);
    @(posedge clk); #1 pd = b;
    repeat (H) @(posedge clk);
    #1 pc = 1'b0;
  endtask

  task automatic bit_rise();
    repeat (H) @(posedge clk);
    #1 pc = 1'b1;
  endtask

  task automatic ps2_bit(input logic b);
    bit_fall(b);
    bit_rise();
  endtask

  task automatic send_body(input logic [7:0] code, input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(~(^code) ^ bad);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad);
    send_body(code, bad);
    ps2_bit(1'b1);
    repeat (6) @(posedge clk);
  endtask

  task automatic drain();
    #1 evt_if.evt_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    evt_if.evt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_code", evt_if.evt_code, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // 2 sync + FL filter cycles to strobe, then 2 more to evt_valid
    evq.delete();
    send_body(8'h1C, 1'b0);
    bit_fall(1'b1);
    repeat (3 + FL) @(posedge clk);
    #1 check("lat_early", evt_if.evt_valid, 0);
    @(posedge clk); #1;
    check("lat_valid", evt_if.evt_valid, 1);
    check("lat_code", evt_if.evt_code, 8'h1C);
    check("lat_flags", {evt_if.evt_ext, evt_if.evt_brk}, 0);
    @(posedge clk); #1;
    check("lat_one_cycle", evt_if.evt_valid, 0);
    bit_rise();
    check("lat_err_cnt", err_cnt, 0);

    evq.delete();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("pfx_count", evq.size(), 2);
    check("pfx_ev0", get(0), 10'h11C);
    check("pfx_ev1", get(1), 10'h375);

    evq.delete();
    f0 = n_ferr;
    send_frame(8'h1C, 1'b1);
    check("par_pulses", n_ferr - f0, 1);
    check("par_err_cnt", err_cnt, 1);
    check("par_no_event", evq.size(), 0);
    send_frame(8'h32, 1'b0);
    check("par_next_ev", get(0), 10'h032);

    evq.delete();
    f0 = n_ferr;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (TO + 100) @(posedge clk);
    #1;
    check("to_pulses", n_ferr - f0, 1);
    check("to_err_cnt", err_cnt, 2);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b1);
    check("to_err_cnt2", err_cnt, 3);
    send_frame(8'h6B, 1'b0);
    check("to_count", evq.size(), 1);
    check("to_ext_cleared", get(0), 10'h06B);

    evq.delete();
    evt_if.evt_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    #1;
    check("ovf_set", overflow, 1);
    check("ovf_head", evt_if.evt_code, 8'h01);
    drain();
    check("ovf_drain_count", evq.size(), 8);
    for (int i = 0; i < 8; i++) check("ovf_drain_order", get(i), 10'(i + 1));
    check("ovf_empty_code", evt_if.evt_code, 0);
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // push lands in the exact cycle the full FIFO is popped
    evq.delete();
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0);
    check("full_no_ovf", overflow, 0);
    send_body(8'h18, 1'b0);
    bit_fall(1'b1);
    repeat (3 + FL) @(posedge clk);
    #1 evt_if.evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_if.evt_ready = 1'b0;
    bit_rise();
    repeat (4) @(posedge clk);
    #1;
    check("pp_no_ovf", overflow, 0);
    drain();
    check("pp_count", evq.size(), 9);
    check("pp_first", get(0), 10'h010);
    check("pp_last", get(8), 10'h018);

`ifdef PS2_ASCII_EN
    evt_if.evt_ready = 1'b0;
    send_frame(8'h16, 1'b0);
    #1 check("ascii_16", evt_if.evt_ascii, 8'h31);
    drain();
    evt_if.evt_ready = 1'b0;
    send_frame(8'h70, 1'b0);
    #1 check("ascii_70", evt_if.evt_ascii, 8'h30);
    drain();
    evt_if.evt_ready = 1'b0;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h16, 1'b0);
    #1 check("ascii_brk", evt_if.evt_ascii, 8'h3F);
    drain();
`endif

    evt_if.evt_ready = 1'b0;
    send_frame(8'h21, 1'b0);
    send_frame(8'h22, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", evt_if.evt_valid, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_code", evt_if.evt_code, 0);
    pc = 1'b1;
    pd = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    evq.delete();
    evt_if.evt_ready = 1'b1;
    send_frame(8'h23, 1'b0);
    check("post_rst_count", evq.size(), 1);
    check("post_rst_ev", get(0), 10'h023);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
Receives keyboard frames on the raw PS/2 clock/data pins and produces key events for the CPU / JTAG-UART character path.
- Synchronises and de-glitches the pins, then deframes 11-bit PS/2 frames.
- Checks start, parity and stop bits, and applies an inter-bit timeout.
- Folds the E0 and F0 prefixes into flags on the following scan code.
- Buffers completed events in a small show-ahead FIFO with a valid/ready handshake.

Parameters:
FILTER_LEN, 8, clk cycles a synchronised PS2_CLK level must be stable before it is accepted
TIMEOUT_CYCLES, 100000, max clk cycles between accepted falling edges inside a frame (2 ms at 50 MHz)
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
ps2_clk_async  in  1  raw PS/2 clock pin
ps2_data_async  in  1  raw PS/2 data pin
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head this cycle
evt_code  out  8  scan code of head event
evt_brk  out  1  head event is a key release (F0 prefix seen)
evt_ext  out  1  head event is an extended key (E0 prefix seen)
frame_err  out  1  one-cycle pulse on a discarded frame
err_cnt  out  8  saturating count of discarded frames
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset values:
  - all outputs 0, FIFO empty, FSM in IDLE, prefix flags cleared.
  - filtered clock = 1, sync registers = 1.
- Reset asserted mid-frame or mid-transfer: everything returns to these values immediately.
- Synchronisation: each pin passes through 2 flops.
- Clock filter: the filtered PS2 clock changes only after the synced level differs from it for FILTER_LEN consecutive cycles.
- A falling edge of the filtered clock is a one-cycle strobe. Data is sampled from the synced data pin in the strobe cycle.
- FSM states and transitions:
  - IDLE: on strobe, if data=0 go to DATA (bit index 0). If data=1, discard.
  - DATA: shift bits in LSB-first; after 8 strobes go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on strobe, finish the frame and go to IDLE.
    - Accept the frame if data=1 and the 9 bits (data + parity) have an odd count of ones.
    - Otherwise it is an error.
- Timeout:
  - A counter clears on every strobe and counts while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYCLES is an error and sends the FSM to IDLE.
- Error handling:
  - Pulse frame_err in the cycle the error is detected.
  - err_cnt increments, saturating at 255.
  - Clear both prefix flags; nothing is pushed.
- Accepted byte 0xE0: set ext flag, no push.
- Accepted byte 0xF0: set brk flag, no push.
- Any other accepted byte:
  - Push {ext, brk, byte} in the cycle after the STOP strobe.
  - Clear both flags.
  - Byte 0xE1 (Pause) is pushed as an ordinary code.
- Latency: with an empty FIFO, evt_valid rises exactly 2 clk after the STOP strobe.
- FIFO:
  - Show-ahead: evt_* reflect the head whenever evt_valid=1.
  - Pop when evt_valid && evt_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full with no pop: event dropped, overflow set to 1.
  - Push and pop in the same cycle when full: both take effect, no overflow.
  - Pop when empty: ignored.
- overflow: ovf_clr clears it. If ovf_clr and a new drop occur in the same cycle, the set wins.
- evt_code/brk/ext are 0 when the FIFO is empty.

Optional Feature:
PS2_ASCII_EN
- Defined:
  - Adds output evt_ascii [7:0], a registered translation of the FIFO head, valid alongside evt_valid.
  - Main-row digits 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45 map to "1".."9","0".
  - Keypad digits 0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D,0x70 map to "1".."9","0".
  - Letters A–Z map to uppercase ASCII.
  - Break events and unknown codes map to "?" (0x3F).
  - Output latency is unchanged: the translation is registered from the FIFO write data.
- Undefined: port and table absent, no other change.

Test Plan:
- Send one valid frame 0x1C with evt_ready=1 -> evt_valid high for 1 cycle 2 clk after the stop edge, evt_code=0x1C, brk=0, ext=0, err_cnt=0.
- Send frames F0,1C, then E0,F0,75 -> exactly 2 events: {code=1C,brk=1,ext=0} and {code=75,brk=1,ext=1}.
- Send 0x1C with a wrong parity bit -> no event, frame_err one pulse, err_cnt=1. A following valid 0x32 -> event code 0x32, flags 0.
- Send start + 5 data bits, stop clocking for >2 ms -> frame_err, err_cnt increments, FSM in IDLE. Then send E0 and corrupt the next frame. A following valid 0x6B -> ext=0, since the error cleared the E0 flag.
- Hold evt_ready=0 and send 9 codes 0x01..0x09 -> 8 held, overflow=1. Drain: codes 0x01..0x08 in order. Pulse ovf_clr -> overflow=0. Also check push and pop in the same cycle while full -> no overflow.
- PS2_ASCII_EN build: 0x16 -> evt_ascii 0x31; 0x70 -> 0x30; F0,16 -> 0x3F.
